// File: rtl/sync_sram_ctl.sv
// Clocked single-port scratch SRAM with registered reads, tri-state data bus and
// self-initialisation after reset or clr. Optional parity: define SYNC_SRAM_PARITY_EN.
module sync_sram_ctl #(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              ceb,
  input  logic              web,
  input  logic              oeb,
  input  logic              clr,
  output logic              ready,
  output logic              perr
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SYNC_SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Stored word format: even parity bit on top of the data when enabled.
  function automatic logic [MEM_W-1:0] encode_f(input logic [DATA_W-1:0] d);
`ifdef SYNC_SRAM_PARITY_EN
    encode_f = {^d, d};
`else
    encode_f = d;
`endif
  endfunction

  function automatic logic word_bad_f(input logic [MEM_W-1:0] w);
`ifdef SYNC_SRAM_PARITY_EN
    word_bad_f = ^w;
`else
    word_bad_f = 1'b0;
`endif
  endfunction

  logic [MEM_W-1:0]  mem [DEPTH];
  state_t            state_r, state_s;
  logic [ADDR_W-1:0] init_cnt_r, init_cnt_s;
  logic [DATA_W-1:0] rd_q_r;
  logic              rd_valid_r;
  logic              ready_r;
  logic              perr_r;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_wa_s;
  logic [MEM_W-1:0]  mem_wd_s;
  logic [MEM_W-1:0]  mem_rd_s;
  logic              rd_en_s;
  logic              drive_s;

  assign mem_rd_s = mem[addr];

  // Next state, init sequencing and array access decode.
  always_comb begin
    state_s    = state_r;
    init_cnt_s = init_cnt_r;
    mem_we_s   = 1'b0;
    mem_wa_s   = addr;
    mem_wd_s   = encode_f(data);
    rd_en_s    = 1'b0;
    case (state_r)
      ST_INIT: begin
        mem_wa_s = init_cnt_r;
        mem_wd_s = encode_f(INIT_VAL);
        if (clr) begin
          init_cnt_s = {ADDR_W{1'b0}};
        end else begin
          mem_we_s   = 1'b1;
          init_cnt_s = init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (init_cnt_r == LAST_ADDR) begin
            state_s = ST_READY;
          end else begin
            state_s = ST_INIT;
          end
        end
      end
      ST_READY: begin
        // clr wins over any access presented in the same cycle.
        if (clr) begin
          state_s    = ST_INIT;
          init_cnt_s = {ADDR_W{1'b0}};
        end else if (!ceb && !web) begin
          mem_we_s = 1'b1;
        end else if (!ceb && web) begin
          rd_en_s = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_s    = ST_INIT;
        init_cnt_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control registers: FSM, init counter, read pipeline, status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {ADDR_W{1'b0}};
      rd_q_r     <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      ready_r    <= 1'b0;
      perr_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      init_cnt_r <= init_cnt_s;
      rd_valid_r <= rd_en_s;
      ready_r    <= (state_s == ST_READY);
      if (rd_en_s) begin
        rd_q_r <= mem_rd_s[DATA_W-1:0];
      end
      if (clr) begin
        perr_r <= 1'b0;
      end else if (rd_en_s && word_bad_f(mem_rd_s)) begin
        perr_r <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset and are rebuilt by the init sweep.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // Drive only for a valid read with output enabled and no write in progress.
  assign drive_s = rd_valid_r & ~oeb & web;
  assign data    = drive_s ? rd_q_r : {DATA_W{1'bz}};
  assign ready   = ready_r;
`ifdef SYNC_SRAM_PARITY_EN
  assign perr    = perr_r;
`else
  assign perr    = 1'b0;
`endif

endmodule
